// File: rtl/pmc_multi.sv
// pmc_multi: bank of N_CH event counters on the data bus, each routed to one
// of N_EV event lines, with level or edge counting and sticky overflow flags.
// Ports: clk (state on falling edge), rst (sync, active-high),
//   ie/iaddr/iout instruction port (unused, iout = 0),
//   de/daddr/drw/din/dout data port (dout combinational from daddr),
//   events (event lines), pmc_irq (OR of ovf & irq_en).
module pmc_multi #(
   parameter int N_CH  = 8,
   parameter int N_EV  = 16,
   parameter int CNT_W = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ie,
   input  logic [31:0]     iaddr,
   output logic [31:0]     iout,
   input  logic            de,
   input  logic [31:0]     daddr,
   input  logic [1:0]      drw,
   input  logic [31:0]     din,
   output logic [31:0]     dout,
   input  logic [N_EV-1:0] events,
   output logic            pmc_irq
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             gen;
   logic [N_CH-1:0]  ovf;
   logic [N_CH-1:0]  en;
   logic [N_CH-1:0]  irq_en;
   logic [N_CH-1:0]  edg;
   logic [7:0]       sel [N_CH];
   logic [CNT_W-1:0] cnt [N_CH];
   logic [CNT_W-1:0] snp [N_CH];
   logic [N_EV-1:0]  prev;

   // Zero-padded to the full 8-bit select range so a select past N_EV
   // picks a constant 0 and the channel never counts.
   logic [255:0]     ev_pad;
   logic [255:0]     prev_pad;

   logic [4:0]       ci;
   logic [4:0]       si;
   logic             is_ctrl;
   logic             is_stat;
   logic             is_cnt;
   logic             is_cfg;
   logic             is_snap;
   logic             wr;
   logic             clr;
   logic             take_snap;
   logic [N_CH-1:0]  hit;
   logic [N_CH-1:0]  cnt_wr;
   logic [N_CH-1:0]  inc;
   logic [N_CH-1:0]  wrap;
   logic [N_CH-1:0]  w1c;
   logic             unused;

   assign unused   = ^{ie, iaddr, drw[1], din};
   assign iout     = '0;

   assign ev_pad   = 256'(events);
   assign prev_pad = 256'(prev);

   assign ci       = daddr[7:3];
   assign si       = daddr[6:2];
   assign is_ctrl  = daddr[31:2] == 30'd0;
   assign is_stat  = daddr[31:2] == 30'd1;
   assign is_cnt   = daddr[31:8] == 24'h1 && !daddr[2];
   assign is_cfg   = daddr[31:8] == 24'h1 && daddr[2];
   assign is_snap  = daddr[31:7] == 25'h4;

   assign wr        = de & drw[0];
   assign clr       = wr & is_ctrl & din[1];
   assign take_snap = wr & is_ctrl & din[2];
   assign w1c       = (wr & is_stat) ? din[N_CH-1:0] : '0;

   assign pmc_irq  = |(ovf & irq_en);

   // A count write or clear on the same edge swallows the increment,
   // so only surviving increments can raise an overflow.
   always_comb begin
      hit    = '0;
      cnt_wr = '0;
      inc    = '0;
      wrap   = '0;
      for (int i = 0; i < N_CH; i++) begin
         hit[i]    = gen & en[i] & ev_pad[sel[i]]
                   & ~(edg[i] & prev_pad[sel[i]]);
         cnt_wr[i] = wr & is_cnt & (ci == 5'(i));
         inc[i]    = hit[i] & ~clr & ~cnt_wr[i];
         wrap[i]   = inc[i] & (cnt[i] == CNT_MAX);
      end
   end

   always_comb begin
      dout = '0;
      if (is_ctrl)
         dout = {31'd0, gen};
      else if (is_stat)
         dout = 32'(ovf);
      for (int i = 0; i < N_CH; i++) begin
         if (is_cnt && ci == 5'(i))
            dout = 32'(cnt[i]);
         if (is_cfg && ci == 5'(i))
            dout = {21'd0, edg[i], irq_en[i], en[i], sel[i]};
         if (is_snap && si == 5'(i))
            dout = 32'(snp[i]);
      end
   end

   always_ff @(negedge clk) begin
      if (rst) begin
         gen    <= 1'b1;
         ovf    <= '0;
         en     <= '1;
         irq_en <= '0;
         edg    <= '0;
         prev   <= '0;
         for (int i = 0; i < N_CH; i++) begin
            sel[i] <= 8'(i);
            cnt[i] <= '0;
            snp[i] <= '0;
         end
      end else begin
         prev <= events;
         if (wr && is_ctrl)
            gen <= din[0];
         // Overflow set wins over a same-edge clear.
         ovf <= (ovf & ~w1c) | wrap;
         for (int i = 0; i < N_CH; i++) begin
            if (clr)
               cnt[i] <= '0;
            else if (cnt_wr[i])
               cnt[i] <= din[CNT_W-1:0];
            else if (inc[i])
               cnt[i] <= cnt[i] + 1'b1;

            if (clr)
               snp[i] <= '0;
            else if (take_snap)
               snp[i] <= cnt[i];

            if (wr && is_cfg && ci == 5'(i)) begin
               sel[i]    <= din[7:0];
               en[i]     <= din[8];
               irq_en[i] <= din[9];
               edg[i]    <= din[10];
            end
         end
      end
   end

endmodule

// File: doc/pmc_multi.md
# pmc_multi

Parametrised performance-monitor counter bank on the data bus. It provides N_CH counters, each routed through a per-channel selector to any of N_EV event inputs, with level or edge counting and a software-writable count value. Each counter has a sticky overflow flag with a maskable interrupt, and the block supports a global freeze, a clear-all and an atomic snapshot of all counters. It attaches to the memory-mapped bus as a slave, and `daddr` is the block-local byte offset.

## Interface

Parameters:
- `N_CH`, default 8: number of counters, 1–32.
- `N_EV`, default 16: number of event inputs, 1–256.
- `CNT_W`, default 32: counter width, 8–32.

Ports:
- `clk`, input, 1: system clock. All state updates on the falling edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `ie`, input, 1: instruction-port enable. Ignored.
- `iaddr`, input, 32: instruction-port address. Ignored.
- `iout`, output, 32: constant 0.
- `de`, input, 1: data-port enable.
- `daddr`, input, 32: data byte offset. Word aligned; bits [1:0] are ignored.
- `drw`, input, 2: `drw[0]` is the write strobe. `drw[1]` (read) is ignored because reads are combinational.
- `din`, input, 32: write data.
- `dout`, output, 32: read data, combinational from `daddr`.
- `events`, input, N_EV: event lines, sampled on the falling edge.
- `pmc_irq`, output, 1: level interrupt. Equals the OR over all channels of (`ovf[i]` & `irq_en[i]`).

## Operation

Address map. Unmapped offsets read 0 and ignore writes.
- 0x000 CTRL:
  - bit0 `gen`: global enable, read/write, reset 1.
  - bit1 `clr`: clear all, write-1 action, reads 0.
  - bit2 `snap`: snapshot, write-1 action, reads 0.
- 0x004 STATUS: `ovf[N_CH-1:0]`, sticky. Writing 1 to a bit clears it (write-1-to-clear).
- 0x100 + 8·i, COUNT[i]:
  - Reads return the counter zero-extended to 32 bits.
  - Writes load `din[CNT_W-1:0]`.
- 0x104 + 8·i, CFG[i]:
  - bits[7:0] `sel`: event select, reset i.
  - bit8 `en`: reset 1.
  - bit9 `irq_en`: reset 0.
  - bit10 `edge`: reset 0.
  - bits[31:11] read 0.
- 0x200 + 4·i, SNAP[i]: read-only shadow of COUNT[i], zero-extended, reset 0.

Counting, per channel per falling edge:
- `hit` = `gen` & `en` & (`sel` < N_EV) & ev, where:
  - ev = `events[sel]` when `edge` = 0.
  - ev = `events[sel]` & ~`prev[sel]` when `edge` = 1. `prev` is the registered sample of `events` from the previous falling edge, reset 0.
- When `hit` is set, the counter increments by 1 modulo 2^CNT_W.
- When `sel` ≥ N_EV, the channel never counts.

Overflow:
- An increment from 2^CNT_W−1 wraps the counter to 0 and sets `ovf[i]`.
- A software write to COUNT never sets `ovf`.

Priority, per edge, highest first:
1. `rst`
2. CTRL `clr`: all counters and all SNAP registers go to 0. `ovf` is unaffected.
3. COUNT[i] write: the written value wins over a same-edge increment, and that increment is lost.
4. Increment.

Snapshot:
- CTRL `snap` copies each counter's pre-edge value into SNAP. Same-edge increments go to the live counters only.
- If `clr` and `snap` are written in the same write, SNAP receives 0.

CTRL writes:
- A write updates `gen` from `din[0]`.
- `gen` takes effect on the following edge. The edge of the write itself uses the old `gen`.

STATUS collisions:
- A write-1-to-clear on a bit that overflows on the same edge leaves the bit set.

Reset values:
- All counters, SNAP, `ovf` and `prev` are 0.
- CFG and CTRL take the values listed above, so that channel i counts event i at level out of reset.
- `pmc_irq` = 0, `iout` = 0.
- `dout` reflects these values combinationally.
- A reset mid-count discards the in-flight increment.

## Timing

- Writes are accepted only when `de` & `drw[0]` is high at a falling edge.
- Register and counter updates are visible on `dout` immediately after that edge. Read latency is 0: `dout` follows `daddr` combinationally.
- Event-to-count latency is 1 falling edge.
- Edge mode needs the event low for at least one sample before a new edge counts.
- A level held for k samples counts k in level mode and 1 in edge mode.
- `pmc_irq` rises after the edge that sets `ovf`. It falls after the STATUS clear edge or the edge that writes `irq_en` to 0.

## Test plan

1. Default counting:
   - Stimulus: reset, then pulse `events[3]` high for 5 edges.
   - Response: COUNT[3] reads 5, all other counters read 0, CTRL reads 0x1, CFG[3] reads 0x103.
2. Edge mode and select:
   - Stimulus: set CFG[0] = 0x505 (sel 5, en, edge). Drive `events[5]` as 1,1,1,0,1,1 across 6 edges.
   - Response: COUNT[0] = 2.
   - Stimulus: set `sel` = 0xFF.
   - Response: COUNT[0] stays 2.
3. Overflow and IRQ:
   - Stimulus: CNT_W = 8, write COUNT[1] = 0xFE, set CFG[1] `irq_en`, assert `events[1]` for 2 edges.
   - Response: COUNT[1] = 0x00, STATUS bit1 = 1, `pmc_irq` = 1.
   - Stimulus: write STATUS = 0x2.
   - Response: `pmc_irq` = 0.
4. Collisions:
   - Stimulus: write COUNT[2] = 0x10 on the same edge as an `events[2]` hit.
   - Response: COUNT[2] reads 0x10.
   - Stimulus: write STATUS bit2 on the same edge as a channel-2 overflow.
   - Response: the bit stays 1.
5. Freeze and snapshot:
   - Stimulus: count `events[4]` for 7 edges, write CTRL = 0x5, then 3 more event edges.
   - Response: SNAP[4] = 7 and COUNT[4] = 10.
   - Stimulus: write CTRL = 0x0, then 4 more event edges.
   - Response: COUNT[4] stays 10.
   - Stimulus: write CTRL = 0x3.
   - Response: all COUNT and SNAP read 0 and CTRL reads 0x1.
6. Reset mid-operation:
   - Stimulus: assert `rst` for 1 edge while events are active and `ovf` is set.
   - Response: all counters 0, STATUS 0, CFG back to defaults, `pmc_irq` 0, unmapped offset 0x300 reads 0.
